// File: rtl/pipe_skid_reg.sv
// pipe_skid_reg: two-entry pipeline register (main + skid) between pipeline stages.
// Latency: one cycle from accept in EMPTY to out_valid; in_ready depends on state and freeze only.
// Backpressure: in_ready drops when both entries are held or freeze is high; flush empties both.
//
// Ports:
//   CLK, RST             single clock, synchronous active-high reset
//   in_valid/in_ready    upstream handshake, payload in_instr[DATA_W], in_npc[PC_W]
//   out_valid/out_ready  downstream handshake, payload out_instr/out_npc (zero when not valid)
//   flush                empties both entries and drops any same-cycle input word
//   freeze               blocks accept and emit, holding all state
//   stall_cnt/flush_cnt  performance counters
//
// Build option: define PIPE_SKID_REG_PERF_EN to include the counters; otherwise
// stall_cnt and flush_cnt are tied to zero and no counter flops are built.
module pipe_skid_reg #(
   parameter int DATA_W = 32,
   parameter int PC_W   = 32
) (
   input  logic              CLK,
   input  logic              RST,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [DATA_W-1:0] in_instr,
   input  logic [PC_W-1:0]   in_npc,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [DATA_W-1:0] out_instr,
   output logic [PC_W-1:0]   out_npc,
   input  logic              flush,
   input  logic              freeze,
   output logic [31:0]       stall_cnt,
   output logic [31:0]       flush_cnt
);

   typedef enum logic [1:0] {
      EMPTY = 2'd0,
      ONE   = 2'd1,
      TWO   = 2'd2
   } state_t;

   state_t            state_q;
   state_t            state_d;
   logic [DATA_W-1:0] main_instr_q;
   logic [PC_W-1:0]   main_npc_q;
   logic [DATA_W-1:0] skid_instr_q;
   logic [PC_W-1:0]   skid_npc_q;
   logic              accept;
   logic              emit;

   // State register
   always_ff @(posedge CLK) begin
      if (RST) begin
         state_q <= EMPTY;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state logic; flush wins over every handshake
   always_comb begin
      state_d = state_q;
      if (flush) begin
         state_d = EMPTY;
      end else begin
         case (state_q)
            EMPTY: if (accept) state_d = ONE;
            ONE: begin
               if (accept && !emit)      state_d = TWO;
               else if (!accept && emit) state_d = EMPTY;
            end
            TWO:     if (emit) state_d = ONE;
            default: state_d = EMPTY;
         endcase
      end
   end

   // Outputs; in_ready looks only at held state and freeze so it never
   // forms a combinational path from out_ready.
   always_comb begin
      in_ready  = (state_q != TWO) && !freeze;
      out_valid = (state_q != EMPTY);
      out_instr = out_valid ? main_instr_q : '0;
      out_npc   = out_valid ? main_npc_q   : '0;
   end

   assign accept = in_valid && in_ready;
   assign emit   = out_valid && out_ready && !freeze;

   // Payload registers. Vacated entries are cleared so a stale word is never
   // left sitting behind an empty slot.
   always_ff @(posedge CLK) begin
      if (RST || flush) begin
         main_instr_q <= '0;
         main_npc_q   <= '0;
         skid_instr_q <= '0;
         skid_npc_q   <= '0;
      end else begin
         case (state_q)
            EMPTY: begin
               if (accept) begin
                  main_instr_q <= in_instr;
                  main_npc_q   <= in_npc;
               end
            end
            ONE: begin
               if (accept && emit) begin
                  main_instr_q <= in_instr;
                  main_npc_q   <= in_npc;
               end else if (accept) begin
                  skid_instr_q <= in_instr;
                  skid_npc_q   <= in_npc;
               end else if (emit) begin
                  main_instr_q <= '0;
                  main_npc_q   <= '0;
               end
            end
            TWO: begin
               // in_ready is low here, so only the skid-to-main move is possible
               if (emit) begin
                  main_instr_q <= skid_instr_q;
                  main_npc_q   <= skid_npc_q;
                  skid_instr_q <= '0;
                  skid_npc_q   <= '0;
               end
            end
            default: ;
         endcase
      end
   end

`ifdef PIPE_SKID_REG_PERF_EN
   logic [31:0] stall_cnt_q;
   logic [31:0] flush_cnt_q;

   // Saturating counters; flush does not clear them, only RST does
   always_ff @(posedge CLK) begin
      if (RST) begin
         stall_cnt_q <= '0;
         flush_cnt_q <= '0;
      end else begin
         if (out_valid && !emit && (stall_cnt_q != 32'hFFFF_FFFF)) begin
            stall_cnt_q <= stall_cnt_q + 32'd1;
         end
         if (flush && (flush_cnt_q != 32'hFFFF_FFFF)) begin
            flush_cnt_q <= flush_cnt_q + 32'd1;
         end
      end
   end

   assign stall_cnt = stall_cnt_q;
   assign flush_cnt = flush_cnt_q;
`else
   assign stall_cnt = '0;
   assign flush_cnt = '0;
`endif

endmodule

// File: tb/tb_pipe_skid_reg.sv
// tb_pipe_skid_reg: directed-vector bench for pipe_skid_reg with hand-computed expectations.
// Inputs change 1 time unit after the rising edge; outputs are sampled 1 unit later.
// Counter expectations follow PIPE_SKID_REG_PERF_EN when it is defined for the bench too.
module tb_pipe_skid_reg;

`ifdef PIPE_SKID_REG_PERF_EN
   localparam bit PERF = 1'b1;
`else
   localparam bit PERF = 1'b0;
`endif

   logic        CLK;
   logic        RST;
   logic        in_valid;
   logic        in_ready;
   logic [31:0] in_instr;
   logic [31:0] in_npc;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] out_instr;
   logic [31:0] out_npc;
   logic        flush;
   logic        freeze;
   logic [31:0] stall_cnt;
   logic [31:0] flush_cnt;

   int n_asserts = 0;
   int n_fail    = 0;

   pipe_skid_reg #(.DATA_W(32), .PC_W(32)) dut (
      .CLK       (CLK),
      .RST       (RST),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_instr  (in_instr),
      .in_npc    (in_npc),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_instr (out_instr),
      .out_npc   (out_npc),
      .flush     (flush),
      .freeze    (freeze),
      .stall_cnt (stall_cnt),
      .flush_cnt (flush_cnt)
   );

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   // Hard stop in case the sequence below ever stalls
   initial begin
      #100000;
      $display("FAIL watchdog: got timeout required end of test");
      $fatal(1);
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_asserts++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h required 0x%08h", tag, got, exp);
      end
   endtask

   // Advance past one rising edge; inputs driven afterwards are clear of it
   task automatic tick();
      @(posedge CLK);
      #1;
   endtask

   task automatic drive(input logic v, input logic [31:0] instr, input logic [31:0] npc);
      in_valid = v;
      in_instr = instr;
      in_npc   = npc;
   endtask

   initial begin
      // Reset with a live input word: it must not be captured
      RST = 1'b1; out_ready = 1'b0; flush = 1'b0; freeze = 1'b0;
      drive(1'b1, 32'hDEAD_BEEF, 32'h0000_BEEF);
      tick(); tick();
      RST = 1'b0;
      drive(1'b0, 32'h0, 32'h0);
      #1;
      chk("rst_out_valid", {31'b0, out_valid}, 32'd0);
      chk("rst_out_instr", out_instr, 32'h0);
      chk("rst_out_npc",   out_npc,   32'h0);
      chk("rst_in_ready",  {31'b0, in_ready}, 32'd1);
      chk("rst_stall_cnt", stall_cnt, 32'h0);
      chk("rst_flush_cnt", flush_cnt, 32'h0);

      // One-cycle latency from EMPTY
      out_ready = 1'b1;
      drive(1'b1, 32'h8C22_0004, 32'h0000_0004);
      tick();
      drive(1'b0, 32'h0, 32'h0);
      #1;
      chk("lat_out_valid", {31'b0, out_valid}, 32'd1);
      chk("lat_out_instr", out_instr, 32'h8C22_0004);
      chk("lat_out_npc",   out_npc,   32'h0000_0004);
      tick();
      chk("bubble_valid", {31'b0, out_valid}, 32'd0);
      chk("bubble_instr", out_instr, 32'h0);
      chk("bubble_npc",   out_npc,   32'h0);

      // Backpressure: A, B fill both entries, C must wait upstream
      out_ready = 1'b0;
      drive(1'b1, 32'h11, 32'h100);
      #1 chk("bp_ready_a", {31'b0, in_ready}, 32'd1);
      tick();
      drive(1'b1, 32'h22, 32'h200);
      #1 chk("bp_ready_b", {31'b0, in_ready}, 32'd1);
      tick();
      drive(1'b1, 32'h33, 32'h300);
      #1;
      chk("bp_ready_c",   {31'b0, in_ready}, 32'd0);
      chk("bp_head_a",    out_instr, 32'h11);
      tick();
      chk("bp_hold_a",    out_instr, 32'h11);
      chk("bp_hold_rdy",  {31'b0, in_ready}, 32'd0);
      out_ready = 1'b1;
      tick();
      chk("order_b_instr", out_instr, 32'h22);
      chk("order_b_npc",   out_npc,   32'h200);
      chk("order_b_ready", {31'b0, in_ready}, 32'd1);
      tick();
      drive(1'b0, 32'h0, 32'h0);
      #1;
      chk("order_c_instr", out_instr, 32'h33);
      chk("order_c_npc",   out_npc,   32'h300);
      tick();
      chk("order_drained", {31'b0, out_valid}, 32'd0);

      // Flush from TWO with a concurrent input word
      out_ready = 1'b0;
      drive(1'b1, 32'h44, 32'h440);
      tick();
      drive(1'b1, 32'h55, 32'h550);
      tick();
      #1 chk("fl_full", {31'b0, in_ready}, 32'd0);
      flush = 1'b1;
      drive(1'b1, 32'h66, 32'h660);
      tick();
      flush = 1'b0;
      drive(1'b0, 32'h0, 32'h0);
      #1;
      chk("fl_out_valid", {31'b0, out_valid}, 32'd0);
      chk("fl_out_instr", out_instr, 32'h0);
      chk("fl_out_npc",   out_npc,   32'h0);
      chk("fl_in_ready",  {31'b0, in_ready}, 32'd1);
      chk("fl_flush_cnt", flush_cnt, PERF ? 32'd1 : 32'd0);
      out_ready = 1'b1;
      tick();
      chk("fl_no_ghost", {31'b0, out_valid}, 32'd0);

      // Freeze in ONE for three cycles with downstream ready
      RST = 1'b1;
      tick();
      RST = 1'b0;
      out_ready = 1'b0;
      drive(1'b1, 32'h77, 32'h770);
      tick();
      freeze = 1'b1;
      out_ready = 1'b1;
      drive(1'b1, 32'h88, 32'h880);
      #1;
      chk("frz_in_ready", {31'b0, in_ready}, 32'd0);
      tick(); tick(); tick();
      chk("frz_out_instr", out_instr, 32'h77);
      chk("frz_out_valid", {31'b0, out_valid}, 32'd1);
      chk("frz_stall_cnt", stall_cnt, PERF ? 32'd3 : 32'd0);
      freeze = 1'b0;
      drive(1'b0, 32'h0, 32'h0);
      tick();
      chk("frz_release_empty", {31'b0, out_valid}, 32'd0);
      chk("frz_stall_after",   stall_cnt, PERF ? 32'd3 : 32'd0);

      // RST beats flush and freeze while in TWO
      out_ready = 1'b0;
      drive(1'b1, 32'h99, 32'h990);
      tick();
      drive(1'b1, 32'hAA, 32'hAA0);
      tick();
      RST = 1'b1; flush = 1'b1; freeze = 1'b1; out_ready = 1'b1;
      tick();
      RST = 1'b0; flush = 1'b0; freeze = 1'b0; out_ready = 1'b0;
      drive(1'b0, 32'h0, 32'h0);
      #1;
      chk("rov_out_valid", {31'b0, out_valid}, 32'd0);
      chk("rov_out_instr", out_instr, 32'h0);
      chk("rov_out_npc",   out_npc,   32'h0);
      chk("rov_in_ready",  {31'b0, in_ready}, 32'd1);
      chk("rov_flush_cnt", flush_cnt, 32'h0);
      chk("rov_stall_cnt", stall_cnt, 32'h0);

      // Stall counter saturation from a preloaded value
      drive(1'b1, 32'hBB, 32'hBB0);
      tick();
      drive(1'b0, 32'h0, 32'h0);
`ifdef PIPE_SKID_REG_PERF_EN
      force dut.stall_cnt_q = 32'hFFFF_FFFE;
      #1;
      release dut.stall_cnt_q;
`endif
      tick(); tick(); tick();
      chk("sat_stall_cnt", stall_cnt, PERF ? 32'hFFFF_FFFF : 32'h0);
      chk("sat_head",      out_instr, 32'hBB);
      tick();
      chk("sat_stall_hold", stall_cnt, PERF ? 32'hFFFF_FFFF : 32'h0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
      $finish;
   end

endmodule
